mem_burst_master: RTL and testbench

- Initiator-side engine for the team's single-port word RAM (cs / active-low web / address / d / q).
- Accepts one burst command at a time: write N words taken from an input stream, or read N words into an output stream.
- Sits between the matrix-multiplier datapath and the RAM instance.
- Owns all RAM control signalling and absorbs downstream backpressure with a 2-entry read buffer.

---
 rtl/mem_burst_master.sv | 178 +++++++++++++++++
 tb/tb_mem_burst_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_master
// Purpose  : Burst initiator for the single-port word RAM. Accepts one
//            command at a time and either writes N words taken from the
//            write stream or reads N words into the read stream through a
//            2-entry buffer that absorbs downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_master #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  // write stream
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  // read stream
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  // completion
  output logic                  done,
  // RAM side
  output logic                  mem_cs,
  output logic                  mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);
  localparam logic [1:0]            c_buf_full = 2'd2;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_cmd_ready;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_remaining;   // words still to be written / popped
  logic [LEN_WIDTH-1:0]    r_issue_left;  // read words still to be fetched
  logic [DATA_WIDTH-1:0]   r_buf [0:1];
  logic                    r_rd_ptr;
  logic                    r_wr_ptr;
  logic [1:0]              r_count;

  logic                    w_accept;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_wr_beat;

  // r_cmd_ready is high only in IDLE, so it doubles as the accept qualifier
  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_pop     = (r_state == S_READ) && (r_count != 2'd0) && rd_ready;
  // a fetch may proceed into a full buffer only when a pop frees a slot
  assign w_issue   = (r_state == S_READ) && (r_issue_left != '0) &&
                     ((r_count != c_buf_full) || w_pop);
  assign w_wr_beat = (r_state == S_WRITE) && wr_valid;

  assign cmd_ready = r_cmd_ready;
  assign mem_addr  = r_addr;
  assign mem_d     = wr_data;
  assign rd_valid  = (r_count != 2'd0);
  assign rd_data   = r_buf[r_rd_ptr];
  // words leave in order, so the head is the final word when one remains
  assign rd_last   = rd_valid && (r_remaining == c_len_one);

  // State register; cmd_ready is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == S_IDLE);
    end
  end

  // Next-state decode and RAM / handshake strobes
  always_comb begin
    w_next_state = r_state;
    mem_cs       = 1'b0;
    mem_web      = 1'b1;
    wr_ready     = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_len == '0)  w_next_state = S_DONE;
          else if (cmd_write) w_next_state = S_WRITE;
          else                w_next_state = S_READ;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        mem_cs   = wr_valid;
        mem_web  = !wr_valid;
        if (wr_valid && (r_remaining == c_len_one)) w_next_state = S_DONE;
      end
      S_READ: begin
        mem_cs = w_issue;
        if (w_pop && (r_remaining == c_len_one)) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Address and burst counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_issue_left <= '0;
    end else if (w_accept) begin
      r_addr       <= cmd_addr;
      r_remaining  <= cmd_len;
      r_issue_left <= cmd_len;
    end else if (w_wr_beat) begin
      r_addr      <= r_addr + c_addr_one;
      r_remaining <= r_remaining - c_len_one;
    end else begin
      if (w_issue) begin
        r_addr       <= r_addr + c_addr_one;
        r_issue_left <= r_issue_left - c_len_one;
      end
      if (w_pop) begin
        r_remaining <= r_remaining - c_len_one;
      end
    end
  end

  // Two-entry read buffer; mem_q is captured on the issue edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_issue) begin
        r_buf[r_wr_ptr] <= mem_q;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_master
// Purpose  : Self-checking bench for mem_burst_master with a RAM model and
//            queue-based scoreboards for RAM writes and read-stream words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        done;
  logic        mem_cs, mem_web;
  logic [15:0] mem_addr;
  logic [63:0] mem_d, mem_q;

  typedef struct packed { logic [63:0] data; logic last; } rexp_t;
  typedef struct packed { logic [15:0] addr; logic [63:0] data; } wexp_t;

  rexp_t       rexp [$];
  wexp_t       wexp [$];
  logic [63:0] ram    [0:65535];
  logic [63:0] shadow [0:65535];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int pop_cnt  = 0;
  int occ      = 0;
  bit    m_pop, m_iss;
  rexp_t m_re;
  wexp_t m_we;

  mem_burst_master #(.DATA_WIDTH(64), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done),
    .mem_cs(mem_cs), .mem_web(mem_web), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read
  always @(posedge clk) if (mem_cs && !mem_web) ram[mem_addr] <= mem_d;
  assign mem_q = ram[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops and buffer occupancy model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
    end else begin
      m_pop = rd_valid && rd_ready;
      m_iss = mem_cs && mem_web;
      chk("rd_valid_vs_occupancy", rd_valid, occ != 0);
      if (occ == 2 && !m_pop) chk("no_fetch_when_full", m_iss, 1'b0);
      if (m_pop) begin
        pop_cnt++;
        chk("rd_word_expected", rexp.size() != 0, 1'b1);
        if (rexp.size() != 0) begin
          m_re = rexp.pop_front();
          chk("rd_data", rd_data, m_re.data);
          chk("rd_last", rd_last, m_re.last);
        end
      end
      if (mem_cs && !mem_web) begin
        chk("ram_write_expected", wexp.size() != 0, 1'b1);
        if (wexp.size() != 0) begin
          m_we = wexp.pop_front();
          chk("ram_write_addr", mem_addr, m_we.addr);
          chk("ram_write_data", mem_d, m_we.data);
        end
      end
      if (done) done_cnt++;
      occ = occ + int'(m_iss) - int'(m_pop);
      if (occ > 2) chk("buffer_overflow", occ, 2);
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
  endtask

  task automatic do_write(input logic [15:0] addr, input int len,
                          input logic [63:0] base, input bit gap);
    int d0;
    logic [15:0] a;
    wait_idle();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len[15:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      a = addr + i[15:0];
      wr_valid = 1'b1;
      wr_data  = base + 64'(i);
      wexp.push_back('{addr: a, data: base + 64'(i)});
      shadow[a] = base + 64'(i);
      if (i == 0) begin #1; chk("wr_ready", wr_ready, 1'b1); end
      @(posedge clk); #1;
      if (gap && i == 1) begin
        wr_valid = 1'b0;
        #1;
        chk("wr_gap_no_cs", mem_cs, 1'b0);
        @(posedge clk); #1;
      end
    end
    wr_valid = 1'b0;
    chk("wr_done_pulse", done, 1'b1);
    chk("wr_ready_in_done", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("wr_done_cleared", done, 1'b0);
    chk("wr_cmd_ready_after", cmd_ready, 1'b1);
    chk("wr_done_count", done_cnt - d0, 1);
    chk("wr_all_beats_seen", wexp.size(), 0);
    for (int i = 0; i < len; i++) begin
      a = addr + i[15:0];
      chk("ram_contents", ram[a], base + 64'(i));
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input int len, input bit bp);
    int d0;
    int cyc;
    logic [15:0] a;
    wait_idle();
    for (int i = 0; i < len; i++) begin
      a = addr + i[15:0];
      rexp.push_back('{data: shadow[a], last: (i == len - 1)});
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len[15:0];
    rd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    d0 = done_cnt;
    if (len == 0) begin
      chk("rd0_done_pulse", done, 1'b1);
      chk("rd0_no_cs", mem_cs, 1'b0);
      @(posedge clk); #1;
      chk("rd0_done_cleared", done, 1'b0);
      chk("rd0_cmd_ready", cmd_ready, 1'b1);
      chk("rd0_done_count", done_cnt - d0, 1);
    end else begin
      cyc = 0;
      while (done_cnt == d0 && cyc < 500) begin
        rd_ready = bp ? (cyc % 3 == 0) : 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      chk("rd_done_seen", done_cnt - d0, 1);
      if (!bp) chk("rd_stream_cycles", cyc, len + 2);
      chk("rd_all_words_seen", rexp.size(), 0);
      chk("rd_cmd_ready_after", cmd_ready, 1'b1);
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, p0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; shadow[i] = '0; end

    // reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mem_cs", mem_cs, 1'b0);
    chk("rst_mem_web", mem_web, 1'b1);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    // basic write / read-back
    do_write(16'h0010, 4, 64'hA0, 1'b0);
    do_read (16'h0010, 4, 1'b0);

    // backpressure read of 6 words (write includes a wr_valid gap)
    do_write(16'h0200, 6, 64'hB0, 1'b1);
    do_read (16'h0200, 6, 1'b1);

    // address wrap
    do_write(16'hFFFE, 3, 64'hC0, 1'b0);
    do_read (16'hFFFE, 3, 1'b0);

    // zero-length bursts
    do_write(16'h0050, 0, 64'hEE, 1'b0);
    do_read (16'h0050, 0, 1'b0);

    // reset in the middle of a read burst
    do_write(16'h0100, 8, 64'hD0, 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++)
      rexp.push_back('{data: shadow[16'h0100 + i[15:0]], last: (i == 7)});
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100; cmd_len = 16'd8;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    p0 = pop_cnt;
    d0 = done_cnt;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_pops_before", pop_cnt - p0, 3);
    chk("midrst_valid_before", rd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_cs", mem_cs, 1'b0);
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    rexp.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cmd_ready_after", cmd_ready, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_ram_access", mem_cs, 1'b0);
    end
    chk("midrst_no_done", done_cnt - d0, 0);
    rd_ready = 1'b0;

    // a normal burst still works after the abort
    do_read(16'h0010, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
